// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline register: occupancy encoding and the
// packed Decode/Execute control bundle carried in the ctrl field.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Callers build in_ctrl with de_ctrl_t'(...) or by assigning a de_ctrl_t.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
    logic [2:0] funct3;
  } de_ctrl_t;

  localparam int DE_CTRL_WIDTH = $bits(de_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the elastic register: valid flag plus ctrl and data.
// clear wins over load, load wins over drain. Draining only drops valid so
// the data field is left untouched.
module pipe_slot #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  drain,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic                  valid,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] data
);

  // Slot register update: reset/clear, capture, or drain.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipereg_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer. The main slot drives
// the outputs; the skid slot absorbs one entry when downstream stalls so that
// in_ready never depends combinationally on out_ready.
//
// state     | meaning
// OCC_EMPTY | no entry held, out_valid=0
// OCC_ONE   | main slot holds the head entry, skid empty
// OCC_FULL  | main holds head, skid holds the next entry, in_ready=0
module pipereg_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output occ_e                  occupancy
);

  occ_e                  occ;
  logic                  main_valid, skid_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_d_data;
  logic                  in_fire, out_fire, clr;
  logic                  main_load, main_drain, skid_load, skid_drain;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = occ;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign clr      = flush;

  // Slot control derived from occupancy and the two handshakes.
  always_comb begin
    main_load  = 1'b0;
    main_drain = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    unique case (occ)
      OCC_EMPTY: main_load = in_fire;
      OCC_ONE: begin
        main_load  = in_fire & out_fire;
        main_drain = !in_fire & out_fire;
        skid_load  = in_fire & !out_fire;
      end
      OCC_FULL: begin
        main_load  = out_fire;
        skid_drain = out_fire;
      end
      default: ;
    endcase
  end

  // Main refills from skid when FULL so the older entry is never overtaken.
  assign main_d_ctrl = (occ == OCC_FULL) ? skid_ctrl : in_ctrl;
  assign main_d_data = (occ == OCC_FULL) ? skid_data : in_data;

  // Occupancy state machine; reset beats flush beats normal handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= OCC_EMPTY;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      unique case (occ)
        OCC_EMPTY: if (in_fire) occ <= OCC_ONE;
        OCC_ONE: begin
          if (in_fire && !out_fire)      occ <= OCC_FULL;
          else if (!in_fire && out_fire) occ <= OCC_EMPTY;
        end
        OCC_FULL:  if (out_fire) occ <= OCC_ONE;
        default:   occ <= OCC_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .load  (main_load),
    .drain (main_drain),
    .d_ctrl(main_d_ctrl),
    .d_data(main_d_data),
    .valid (main_valid),
    .ctrl  (main_ctrl),
    .data  (main_data)
  );

  pipe_slot #(
    .CTRL_WIDTH(CTRL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .load  (skid_load),
    .drain (skid_drain),
    .d_ctrl(in_ctrl),
    .d_data(in_data),
    .valid (skid_valid),
    .ctrl  (skid_ctrl),
    .data  (skid_data)
  );

endmodule

// File: tb/tb_pipereg_elastic.sv
// Scoreboard bench for pipereg_elastic: directed stimulus pushes expected
// entries, an independent negedge monitor pops them on every output transfer.
module tb_pipereg_elastic;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  occ_e        occupancy;

  logic        nc_rst_n, nc_flush, nc_in_valid, nc_out_ready;
  logic [15:0] nc_in_ctrl;
  logic [31:0] nc_in_data;
  logic        nc_in_ready, nc_out_valid;
  logic [15:0] nc_out_ctrl;
  logic [31:0] nc_out_data;
  occ_e        nc_occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] sb_q[$];
  de_ctrl_t    dc;

  always #5 clk = ~clk;

  pipereg_elastic #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipereg_elastic #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .CLEAR_DATA(1'b0)) dut_nc (
    .clk(clk), .rst_n(nc_rst_n), .flush(nc_flush),
    .in_valid(nc_in_valid), .in_ready(nc_in_ready), .in_ctrl(nc_in_ctrl), .in_data(nc_in_data),
    .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_ctrl(nc_out_ctrl), .out_data(nc_out_data),
    .occupancy(nc_occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got data 0x%0h ctrl 0x%0h, expected no transfer", out_data, out_ctrl);
      end else begin
        logic [47:0] e;
        e = sb_q.pop_front();
        chk("sb_ctrl", {48'd0, out_ctrl}, {48'd0, e[47:32]});
        chk("sb_data", {32'd0, out_data}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 16'hFFFF; in_data = 32'h1234_5678;
    nc_rst_n = 1'b0; nc_flush = 1'b0; nc_in_valid = 1'b0; nc_out_ready = 1'b0;
    nc_in_ctrl = 16'h0; nc_in_data = 32'h0;

    // Reset for two edges with a push attempt that must be discarded
    repeat (2) begin
      tick();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {48'd0, out_ctrl}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);

    // Single push
    rst_n = 1'b1; nc_rst_n = 1'b1;
    dc = de_ctrl_t'(16'h00A5);
    in_ctrl = dc; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    sb_q.push_back({16'h00A5, 32'hDEAD_BEEF});
    tick();
    chk("push_out_valid", {63'd0, out_valid}, 64'd1);
    chk("push_out_ctrl", {48'd0, out_ctrl}, 64'h00A5);
    chk("push_out_data", {32'd0, out_data}, 64'hDEAD_BEEF);
    chk("push_occ", {62'd0, occupancy}, 64'd1);
    in_valid = 1'b0;
    tick();
    chk("push_drain_occ", {62'd0, occupancy}, 64'd0);
    chk("push_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("push_drain_ctrl", {48'd0, out_ctrl}, 64'd0);

    // Back-pressure fill: 1 and 2 accepted, 3 refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 32'h1;
    sb_q.push_back({16'h0011, 32'h1});
    tick();
    chk("fill1_occ", {62'd0, occupancy}, 64'd1);
    chk("fill1_data", {32'd0, out_data}, 64'h1);
    chk("fill2_in_ready", {63'd0, in_ready}, 64'd1);
    in_ctrl = 16'h0022; in_data = 32'h2;
    sb_q.push_back({16'h0022, 32'h2});
    tick();
    chk("fill2_occ", {62'd0, occupancy}, 64'd2);
    chk("fill2_data", {32'd0, out_data}, 64'h1);
    chk("fill3_in_ready", {63'd0, in_ready}, 64'd0);
    in_ctrl = 16'h0033; in_data = 32'h3;
    tick();
    chk("fill3_occ", {62'd0, occupancy}, 64'd2);
    chk("fill3_data", {32'd0, out_data}, 64'h1);
    chk("fill3_ctrl", {48'd0, out_ctrl}, 64'h0011);

    // Drain in order
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain1_occ", {62'd0, occupancy}, 64'd1);
    chk("drain1_data", {32'd0, out_data}, 64'h2);
    tick();
    chk("drain2_occ", {62'd0, occupancy}, 64'd0);
    chk("drain2_valid", {63'd0, out_valid}, 64'd0);
    chk("drain2_ctrl", {48'd0, out_ctrl}, 64'd0);

    // Streaming at one entry per cycle
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = i; in_ctrl = 16'(i) ^ 16'h5A5A;
      sb_q.push_back({16'(i) ^ 16'h5A5A, 32'(i)});
      tick();
      chk("stream_data", {32'd0, out_data}, 64'(i));
      chk("stream_occ", {62'd0, occupancy}, 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_occ", {62'd0, occupancy}, 64'd0);
    chk("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Flush while FULL with a concurrent push
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 16'h0101; in_data = 32'h10;
    tick();
    in_ctrl = 16'h0202; in_data = 32'h20;
    tick();
    chk("pre_flush_occ", {62'd0, occupancy}, 64'd2);
    flush = 1'b1; in_ctrl = 16'h0707; in_data = 32'h77;
    tick();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl", {48'd0, out_ctrl}, 64'd0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_data", {32'd0, out_data}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("post_flush_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; in_ctrl = 16'h0808; in_data = 32'h88;
    sb_q.push_back({16'h0808, 32'h88});
    tick();
    chk("post_flush_push_valid", {63'd0, out_valid}, 64'd1);
    chk("post_flush_push_data", {32'd0, out_data}, 64'h88);

    // Flush together with an output transfer: that transfer still completes
    in_ctrl = 16'h0909; in_data = 32'h99;
    sb_q.push_back({16'h0909, 32'h99});
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_xfer_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_xfer_sb_empty", 64'(sb_q.size()), 64'd0);
    out_ready = 1'b0;

    // CLEAR_DATA=0: reset keeps data, clears valid/ctrl, drops a push
    nc_in_valid = 1'b1; nc_in_ctrl = 16'h0003; nc_in_data = 32'hCAFE;
    tick();
    chk("nc_load_valid", {63'd0, nc_out_valid}, 64'd1);
    chk("nc_load_data", {32'd0, nc_out_data}, 64'hCAFE);
    nc_rst_n = 1'b0; nc_in_ctrl = 16'h0004; nc_in_data = 32'hBAD;
    tick();
    chk("nc_rst_valid", {63'd0, nc_out_valid}, 64'd0);
    chk("nc_rst_ctrl", {48'd0, nc_out_ctrl}, 64'd0);
    chk("nc_rst_data", {32'd0, nc_out_data}, 64'hCAFE);
    chk("nc_rst_occ", {62'd0, nc_occupancy}, 64'd0);
    chk("nc_rst_in_ready", {63'd0, nc_in_ready}, 64'd1);
    nc_rst_n = 1'b1; nc_in_valid = 1'b0;
    tick();
    chk("nc_post_rst_valid", {63'd0, nc_out_valid}, 64'd0);

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipereg_elastic.md
Name: pipereg_elastic

Overview:
Parametrised elastic pipeline register. It replaces fixed enable/clear stage registers between pipeline stages with a valid/ready handshake and a 2-entry skid buffer. Payload is split into a control field and a data field. The control field is forced to zero whenever the stage holds a bubble, and the data field is optionally zeroed on reset or flush. It is used between Decode/Execute and later stages so that stalls propagate through back-pressure instead of global enables.

Parameters:
DATA_WIDTH, 32, width of data payload (operands, PC, immediate, rd packed).
CTRL_WIDTH, 16, width of control payload (RegWrite, MemWrite, ALUCtrl etc. packed).
CLEAR_DATA, 1, 1 = data storage zeroed on reset/flush; 0 = only valid and ctrl cleared.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous flush (branch/jump mispredict); drops all held and incoming entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_ctrl  input  CTRL_WIDTH  upstream control payload
in_data  input  DATA_WIDTH  upstream data payload
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts entry
out_ctrl  output  CTRL_WIDTH  control payload; all-zero when out_valid=0
out_data  output  DATA_WIDTH  data payload of head entry
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage: main slot (drives outputs) plus skid slot. Each slot holds valid, ctrl and data.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid.valid. It is combinational from registered state only, with no path from out_ready, so it is 1 whenever occupancy < 2.
- Port mapping: out_valid = main.valid; out_data = main.data; out_ctrl = main.valid ? main.ctrl : 0.
- Occupancy states, with next state on rising edge:
  - EMPTY(0): in_fire → ONE, main <= in.
  - ONE(1):
    - in_fire & out_fire → ONE, main <= in.
    - in_fire & !out_fire → FULL, skid <= in.
    - !in_fire & out_fire → EMPTY.
    - else hold.
  - FULL(2): in_ready=0.
    - out_fire → ONE, main <= skid, skid invalid.
    - else hold.
  - FULL→EMPTY in one cycle is impossible.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Sustained throughput is 1 entry/cycle with out_ready=1.
- Ordering: strict FIFO. The skid entry is never overtaken by a newer entry.
- Stability: while out_valid & !out_ready, out_ctrl and out_data are held unchanged.
- Data retention: data is not modified when a slot drains, so a stale out_data value is permitted while out_valid=0. Ctrl is always masked.
- Priority on a rising edge: reset > flush > normal operation.
- Reset (rst_n=0 at edge):
  - Both slots invalid; occupancy=0; out_valid=0; out_ctrl=0.
  - out_data=0 if CLEAR_DATA=1, else unchanged.
  - in_ready reads 1 during and after reset, but any in_fire while rst_n=0 is discarded.
- Flush (flush=1 at edge, rst_n=1):
  - Same slot clearing as reset.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle is still a completed transfer from the downstream point of view.
  - After flush, the next in_fire produces out_valid one cycle later.
- Reset or flush asserted mid-operation while FULL: both entries are lost and no partial state remains.

Decomposition:
- Package pipe_pkg:
  - occ_e enum (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2), the type of occupancy.
  - Packed struct typedef for the D/E control bundle, so callers build in_ctrl by casting.
- One natural sub-module: pipe_slot, a valid+ctrl+data register with load and clear inputs and a CLEAR_DATA parameter.
  - Instantiated twice: main and skid.
  - The top level holds only the occupancy state and slot-select muxing.

Test Plan:
- Reset then single push: rst_n low 2 cycles, then in_valid=1, in_ctrl=16'h00A5, in_data=32'hDEADBEEF, out_ready=1 → out_valid=1 next cycle with the same values; occupancy 1 then 0; before the push, out_ctrl=0 and out_data=0.
- Back-pressure fill: out_ready=0, push 32'h1, 32'h2, 32'h3 on consecutive cycles → first two accepted, occupancy=2, in_ready=0 on the third cycle, 32'h3 not accepted; out_data held at 32'h1 throughout.
- Drain order: from FULL (32'h1, 32'h2), set out_ready=1 with in_valid=0 → out_data 32'h1 then 32'h2 on consecutive cycles, then out_valid=0 with out_ctrl=0; occupancy 2→1→0.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with in_data=cycle index → out_data lags input by exactly 1 cycle; occupancy constantly 1; no drops or duplicates.
- Flush while FULL with concurrent push: occupancy=2, assert flush with in_valid=1 and in_data=32'h77 → next cycle out_valid=0, out_ctrl=0, occupancy=0, out_data=0 (CLEAR_DATA=1); 32'h77 never appears at the output.
- CLEAR_DATA=0 with reset mid-operation: hold 32'hCAFE in main, pulse rst_n low for 1 cycle → out_valid=0, out_ctrl=0, out_data still 32'hCAFE.
